// File: rtl/card_pkg.sv
// ---------------------------------------------------------------------------
// card_pkg
// Shared types and constants for the card dealer slice.
//   suit_t        : suit encoding, ordered to match the card image ROM banks
//   rank_t        : 4-bit rank, 1..13 valid, 0 marks an empty slot
//   deal_state_t  : deal FSM states
//   cardIndex()   : dense 0..51 index of a card, used by the no-repeat mask
//   rankValid()   : true for ranks 1..13
// ---------------------------------------------------------------------------
package card_pkg;

    typedef enum logic [1:0] {
        TREFL = 2'd0,
        PIK   = 2'd1,
        SERCE = 2'd2,
        ROMB  = 2'd3
    } suit_t;

    typedef logic [3:0] rank_t;

    localparam int MAX_CARDS_DEFAULT = 9;
    localparam int LFSR_W            = 16;
    localparam int DECK_SIZE         = 52;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAW   = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } deal_state_t;

    // Suit-major packing (suit*13 + rank-1) keeps the used mask at exactly
    // 52 bits; a raw {suit, rank-1} concatenation would need 64.
    function automatic logic [5:0] cardIndex(input suit_t s, input rank_t r);
        return 6'(s) * 6'd13 + 6'(r) - 6'd1;
    endfunction

    function automatic logic rankValid(input rank_t r);
        return (r >= 4'd1) && (r <= 4'd13);
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// ---------------------------------------------------------------------------
// card_lfsr
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, stepping every clock.
// Ports:
//   clk     : posedge clock
//   rst_n   : asynchronous active-low reset, loads SEED
//   o_state : current 16-bit LFSR state
// SEED must be non-zero or the register locks up at all zeros.
// ---------------------------------------------------------------------------
module card_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_state
);

    logic [15:0] r_state;
    logic        w_feedback;

    // Taps 16,14,13,11 map to bits 15,13,12,10; the new bit enters at bit 0.
    assign w_feedback = r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else begin
            r_state <= {r_state[14:0], w_feedback};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/card_dealer_ctrl.sv
// ---------------------------------------------------------------------------
// card_dealer_ctrl
// Deals random cards into a player hand and a dealer hand.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   new_round             : pulse, clears both hands and aborts any deal
//   deal_req, deal_target : pulse to deal one card; target 0=player 1=dealer
//   deal_busy             : high while a deal is in flight (DRAW..DONE)
//   deal_done / deal_err  : one-cycle pulses, card committed / hand full
//   *_card_symbols        : suit per slot, *_card_ranks : rank per slot
//   player_count, dealer_count : filled slots per hand
// Optional feature: define CARD_DEAL_NO_REPEAT_EN to forbid dealing the same
// card twice within a round (52-bit used mask). Without it, duplicates occur.
// ---------------------------------------------------------------------------
module card_dealer_ctrl
    import card_pkg::*;
#(
    parameter int          MAX_CARDS = MAX_CARDS_DEFAULT,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       new_round,
    input  logic                       deal_req,
    input  logic                       deal_target,
    output logic                       deal_busy,
    output logic                       deal_done,
    output logic                       deal_err,
    output logic [0:MAX_CARDS-1][1:0]  player_card_symbols,
    output logic [0:MAX_CARDS-1][1:0]  dealer_card_symbols,
    output logic [0:MAX_CARDS-1][3:0]  player_card_ranks,
    output logic [0:MAX_CARDS-1][3:0]  dealer_card_ranks,
    output logic [3:0]                 player_count,
    output logic [3:0]                 dealer_count
);

    logic [LFSR_W-1:0]         w_lfsr;
    logic                      w_unusedLfsr;
    deal_state_t               r_state;
    deal_state_t               w_nextState;
    logic                      r_target;
    suit_t                     r_candSuit;
    rank_t                     r_candRank;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;
    logic [0:MAX_CARDS-1][1:0] r_playerSuit;
    logic [0:MAX_CARDS-1][1:0] r_dealerSuit;
    logic [0:MAX_CARDS-1][3:0] r_playerRank;
    logic [0:MAX_CARDS-1][3:0] r_dealerRank;
    logic [3:0]                r_playerCount;
    logic [3:0]                r_dealerCount;
    logic [3:0]                w_targetCount;
    logic                      w_targetFull;
    logic                      w_accept;
    logic                      w_refuse;
    logic                      w_candOk;

    card_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_state (w_lfsr)
    );

    // Only the low six bits feed the candidate card.
    assign w_unusedLfsr = ^w_lfsr[15:6];

    // Request decode happens only in IDLE; new_round always takes priority.
    assign w_targetCount = deal_target ? r_dealerCount : r_playerCount;
    assign w_targetFull  = (w_targetCount == 4'(MAX_CARDS));
    assign w_accept      = (r_state == IDLE) && deal_req && !new_round && !w_targetFull;
    assign w_refuse      = (r_state == IDLE) && deal_req && !new_round && w_targetFull;

`ifdef CARD_DEAL_NO_REPEAT_EN
    logic [DECK_SIZE-1:0] r_usedMask;

    // rankValid gates the mask lookup so an out-of-range index never matters.
    assign w_candOk = rankValid(r_candRank) &&
                      !r_usedMask[cardIndex(r_candSuit, r_candRank)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_usedMask <= '0;
        end else if (new_round) begin
            r_usedMask <= '0;
        end else if (r_state == COMMIT) begin
            r_usedMask[cardIndex(r_candSuit, r_candRank)] <= 1'b1;
        end
    end
`else
    assign w_candOk = rankValid(r_candRank);
`endif

    // Next-state logic; rejected candidates loop back to DRAW, which picks up
    // a fresh LFSR value because the LFSR keeps stepping every cycle.
    always_comb begin
        w_nextState = r_state;
        if (new_round) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_nextState = DRAW;
                DRAW:    w_nextState = CHECK;
                CHECK:   w_nextState = w_candOk ? COMMIT : DRAW;
                COMMIT:  w_nextState = DONE;
                DONE:    w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // State register plus status flags, all registered from the next state
    // so busy/done line up exactly with the DRAW..DONE and DONE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_target   <= 1'b0;
            r_candSuit <= TREFL;
            r_candRank <= '0;
        end else begin
            r_state <= w_nextState;
            r_busy  <= (w_nextState != IDLE);
            r_done  <= (w_nextState == DONE);
            r_err   <= w_refuse;
            if (w_accept) begin
                r_target <= deal_target;
            end
            if (r_state == DRAW) begin
                r_candSuit <= suit_t'(w_lfsr[1:0]);
                r_candRank <= w_lfsr[5:2];
            end
        end
    end

    // Hand storage. Slots fill strictly in order, so every slot at or above
    // the count still holds the cleared value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_playerSuit  <= '0;
            r_dealerSuit  <= '0;
            r_playerRank  <= '0;
            r_dealerRank  <= '0;
            r_playerCount <= '0;
            r_dealerCount <= '0;
        end else if (new_round) begin
            r_playerSuit  <= '0;
            r_dealerSuit  <= '0;
            r_playerRank  <= '0;
            r_dealerRank  <= '0;
            r_playerCount <= '0;
            r_dealerCount <= '0;
        end else if (r_state == COMMIT) begin
            if (r_target) begin
                r_dealerSuit[r_dealerCount] <= r_candSuit;
                r_dealerRank[r_dealerCount] <= r_candRank;
                r_dealerCount               <= r_dealerCount + 4'd1;
            end else begin
                r_playerSuit[r_playerCount] <= r_candSuit;
                r_playerRank[r_playerCount] <= r_candRank;
                r_playerCount               <= r_playerCount + 4'd1;
            end
        end
    end

    assign deal_busy           = r_busy;
    assign deal_done           = r_done;
    assign deal_err            = r_err;
    assign player_card_symbols = r_playerSuit;
    assign dealer_card_symbols = r_dealerSuit;
    assign player_card_ranks   = r_playerRank;
    assign dealer_card_ranks   = r_dealerRank;
    assign player_count        = r_playerCount;
    assign dealer_count        = r_dealerCount;

endmodule

// File: tb/tb_card_dealer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_card_dealer_ctrl
// Scoreboard bench for card_dealer_ctrl. Each issued deal predicts its card,
// latency and resulting count from an independent LFSR model; a monitor pops
// and compares on every deal_done/deal_err. Define CARD_DEAL_NO_REPEAT_EN to
// also exercise the no-repeat mask over 200 full rounds.
// ---------------------------------------------------------------------------
module tb_card_dealer_ctrl;
    import card_pkg::*;

    localparam int          MC   = MAX_CARDS_DEFAULT;
    localparam logic [15:0] SEED = 16'hACE1;

    logic                clk         = 1'b0;
    logic                rst_n       = 1'b0;
    logic                new_round   = 1'b0;
    logic                deal_req    = 1'b0;
    logic                deal_target = 1'b0;
    logic                deal_busy;
    logic                deal_done;
    logic                deal_err;
    logic [0:MC-1][1:0]  player_card_symbols;
    logic [0:MC-1][1:0]  dealer_card_symbols;
    logic [0:MC-1][3:0]  player_card_ranks;
    logic [0:MC-1][3:0]  dealer_card_ranks;
    logic [3:0]          player_count;
    logic [3:0]          dealer_count;

    card_dealer_ctrl #(
        .MAX_CARDS (MC),
        .LFSR_SEED (SEED)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .new_round           (new_round),
        .deal_req            (deal_req),
        .deal_target         (deal_target),
        .deal_busy           (deal_busy),
        .deal_done           (deal_done),
        .deal_err            (deal_err),
        .player_card_symbols (player_card_symbols),
        .dealer_card_symbols (dealer_card_symbols),
        .player_card_ranks   (player_card_ranks),
        .dealer_card_ranks   (dealer_card_ranks),
        .player_count        (player_count),
        .dealer_count        (dealer_count)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle = cycle + 1;

    // Reference LFSR: taps 16,14,13,11, seeded on reset, steps every clock.
    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    logic [15:0] mLfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mLfsr <= SEED;
        else        mLfsr <= lfsrStep(mLfsr);
    end

    typedef struct {
        bit       isErr;
        bit       target;
        int       suit;
        int       rank;
        int       slot;
        int       count;
        int       latency;
        int       issueCycle;
    } exp_t;

    exp_t sbQ[$];
    exp_t monE;

    int expSuit [2][MC];
    int expRank [2][MC];
    int expCount[2];
    bit usedSet [DECK_SIZE];

    int nChecks = 0;
    int nErrors = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void clearShadow();
        for (int t = 0; t < 2; t++) begin
            expCount[t] = 0;
            for (int i = 0; i < MC; i++) begin
                expSuit[t][i] = 0;
                expRank[t][i] = 0;
            end
        end
        for (int i = 0; i < DECK_SIZE; i++) usedSet[i] = 1'b0;
    endfunction

    function automatic bit candidateOk(input int suit, input int rank);
        if (rank < 1 || rank > 13) return 1'b0;
`ifdef CARD_DEAL_NO_REPEAT_EN
        if (usedSet[suit * 13 + rank - 1]) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge. The request is sampled at the next posedge; the
    // first DRAW samples the LFSR one step later, each retry two more.
    task automatic applyStimulus(input bit target, input bit expectResp);
        exp_t        e;
        logic [15:0] s;
        if (expectResp) begin
            e.target     = target;
            e.issueCycle = cycle;
            e.isErr      = 1'b0;
            e.suit       = 0;
            e.rank       = 0;
            e.slot       = 0;
            if (expCount[target] >= MC) begin
                e.isErr   = 1'b1;
                e.latency = 1;
                e.count   = MC;
            end else begin
                s         = lfsrStep(mLfsr);
                e.latency = 4;
                for (int k = 0; k < 1000; k++) begin
                    if (candidateOk(int'(s[1:0]), int'(s[5:2]))) break;
                    s         = lfsrStep(lfsrStep(s));
                    e.latency = e.latency + 2;
                end
                e.suit = int'(s[1:0]);
                e.rank = int'(s[5:2]);
                e.slot = expCount[target];
                expSuit[target][e.slot] = e.suit;
                expRank[target][e.slot] = e.rank;
                expCount[target]        = expCount[target] + 1;
                e.count                 = expCount[target];
                usedSet[e.suit * 13 + e.rank - 1] = 1'b1;
            end
            sbQ.push_back(e);
        end
        deal_target = target;
        deal_req    = 1'b1;
        @(negedge clk);
        deal_req    = 1'b0;
    endtask

    task automatic newRound();
        new_round = 1'b1;
        @(negedge clk);
        new_round = 1'b0;
        clearShadow();
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && !deal_busy) return;
        end
        nChecks++;
        nErrors++;
        $display("[TB] FAIL wait_idle: got %0d pending responses busy=%0b, required 0 and idle",
                 sbQ.size(), deal_busy);
        sbQ.delete();
    endtask

    task automatic checkHands(input string tag);
        int act;
        int dupes;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < MC; i++) begin
                act = (t == 1) ? int'(dealer_card_symbols[i]) : int'(player_card_symbols[i]);
                checkOutput($sformatf("%s_suit_h%0d_s%0d", tag, t, i), act, expSuit[t][i]);
                act = (t == 1) ? int'(dealer_card_ranks[i]) : int'(player_card_ranks[i]);
                checkOutput($sformatf("%s_rank_h%0d_s%0d", tag, t, i), act, expRank[t][i]);
            end
        end
        checkOutput({tag, "_player_count"}, int'(player_count), expCount[0]);
        checkOutput({tag, "_dealer_count"}, int'(dealer_count), expCount[1]);
`ifdef CARD_DEAL_NO_REPEAT_EN
        dupes = 0;
        for (int a = 0; a < 2 * MC; a++) begin
            for (int b = a + 1; b < 2 * MC; b++) begin
                if (a % MC < int'(a < MC ? player_count : dealer_count) &&
                    b % MC < int'(b < MC ? player_count : dealer_count)) begin
                    if ((a < MC ? player_card_symbols[a % MC] : dealer_card_symbols[a % MC]) ==
                        (b < MC ? player_card_symbols[b % MC] : dealer_card_symbols[b % MC]) &&
                        (a < MC ? player_card_ranks[a % MC] : dealer_card_ranks[a % MC]) ==
                        (b < MC ? player_card_ranks[b % MC] : dealer_card_ranks[b % MC]))
                        dupes++;
                end
            end
        end
        checkOutput({tag, "_duplicates"}, dupes, 0);
`else
        dupes = 0;
`endif
    endtask

    // Monitor: every done/err pulse must match the oldest outstanding deal.
    always @(negedge clk) begin
        if (rst_n && (deal_done || deal_err)) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("[TB] FAIL unexpected_resp: got done=%0b err=%0b, required no response",
                         deal_done, deal_err);
            end else begin
                monE = sbQ.pop_front();
                checkOutput("resp_err",  int'(deal_err),  int'(monE.isErr));
                checkOutput("resp_done", int'(deal_done), int'(!monE.isErr));
                checkOutput("resp_latency", cycle - monE.issueCycle, monE.latency);
                if (!monE.isErr) begin
                    checkOutput("resp_suit",
                        monE.target ? int'(dealer_card_symbols[monE.slot])
                                    : int'(player_card_symbols[monE.slot]), monE.suit);
                    checkOutput("resp_rank",
                        monE.target ? int'(dealer_card_ranks[monE.slot])
                                    : int'(player_card_ranks[monE.slot]), monE.rank);
                end
                checkOutput("resp_count",
                    monE.target ? int'(dealer_count) : int'(player_count), monE.count);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearShadow();
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_busy", int'(deal_busy), 0);
        checkOutput("rst_done", int'(deal_done), 0);
        checkOutput("rst_err",  int'(deal_err),  0);
        checkHands("rst");
        rst_n = 1'b1;

        // Two player and two dealer deals
        applyStimulus(1'b0, 1'b1); waitIdle();
        applyStimulus(1'b0, 1'b1); waitIdle();
        applyStimulus(1'b1, 1'b1); waitIdle();
        applyStimulus(1'b1, 1'b1); waitIdle();
        checkHands("basic");

        // Fill the player hand, then one deal too many
        newRound();
        for (int i = 0; i < MC; i++) begin
            applyStimulus(1'b0, 1'b1);
            waitIdle();
        end
        applyStimulus(1'b0, 1'b1);
        waitIdle();
        checkHands("full");

        // Second request while busy is ignored
        newRound();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        waitIdle();
        checkHands("busy_ignore");

        // new_round two cycles after a request aborts it
        newRound();
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        newRound();
        repeat (8) @(negedge clk);
        checkOutput("abort_busy", int'(deal_busy), 0);
        checkHands("abort");

        // new_round and deal_req together: request dropped
        new_round   = 1'b1;
        deal_req    = 1'b1;
        deal_target = 1'b1;
        @(negedge clk);
        new_round = 1'b0;
        deal_req  = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("simul_busy", int'(deal_busy), 0);
        checkHands("simul");

        // Reset asserted while the FSM sits in CHECK
        applyStimulus(1'b1, 1'b1);
        waitIdle();
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("check_busy", int'(deal_busy), 1);
        rst_n = 1'b0;
        #1;
        clearShadow();
        checkOutput("async_busy", int'(deal_busy), 0);
        checkOutput("async_done", int'(deal_done), 0);
        checkOutput("async_err",  int'(deal_err),  0);
        checkHands("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1);
        waitIdle();
        checkHands("post_rst");

`ifdef CARD_DEAL_NO_REPEAT_EN
        // Full rounds with the no-repeat mask
        for (int r = 0; r < 200; r++) begin
            newRound();
            for (int i = 0; i < MC; i++) begin
                applyStimulus(1'b0, 1'b1); waitIdle();
                applyStimulus(1'b1, 1'b1); waitIdle();
            end
            checkHands("round");
        end
`endif

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
